// File: rtl/wb_gpio_pulse.sv
// wb_gpio_pulse: Wishbone GPIO with set/clr/toggle, one-shot pulse engine, synchronised input and rising-edge irq
//   clk, rst             system clock, asynchronous active-high reset
//   wb_adr_i..wb_ack_o   Wishbone slave, single-cycle ack, registered read data, adr[5:2] decoded
//   gpio_in              asynchronous pin inputs
//   gpio_out             out_reg OR'ed with the pulse mask while the pulse counter runs
//   gpio_oe              per-bit output enable (DIR register)
//   irq                  registered OR of enabled edge status bits
module wb_gpio_pulse #(
    parameter int GPIO_WIDTH  = 8,
    parameter int PULSE_CW    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);
    localparam int GW = GPIO_WIDTH;
    logic [GW-1:0]                  r_out, r_dir, r_mask, r_edge, r_en, r_prev;
    logic [SYNC_STAGES-1:0][GW-1:0] r_sync;
    logic [PULSE_CW-1:0]            r_cnt, r_plen;
    logic [31:0]                    r_dat;
    logic                           r_ack, r_irq;
    logic                           w_acc, w_wr, w_active, w_pls, w_unused;
    logic [3:0]                     w_sel;
    logic [GW-1:0]                  w_d, w_sync, w_rise, w_w1c;
    logic [31:0]                    w_rdata;
    assign w_acc    = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr     = w_acc & wb_we_i;
    assign w_sel    = wb_adr_i[5:2];
    assign w_d      = wb_dat_i[GW-1:0];
    assign w_active = r_cnt != '0;
    // a zero pulse length would never assert the pins, so the write is dropped entirely
    assign w_pls    = w_wr && w_sel == 4'd6 && r_plen != '0;
    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync & ~r_prev;
    assign w_w1c    = (w_wr && w_sel == 4'd8) ? w_d : '0;
    assign w_unused = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i};
    assign gpio_out = r_out | (w_active ? r_mask : '0);
    assign gpio_oe  = r_dir;
    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign irq      = r_irq;
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            4'd0: w_rdata[GW-1:0] = r_out;
            4'd4: w_rdata[GW-1:0] = r_dir;
            4'd5: w_rdata[GW-1:0] = w_sync;
            4'd6: w_rdata[GW-1:0] = w_active ? r_mask : '0;
            4'd7: w_rdata[PULSE_CW-1:0] = r_plen;
            4'd8: w_rdata[GW-1:0] = r_edge;
            4'd9: w_rdata[GW-1:0] = r_en;
            default: w_rdata = '0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_dir  <= '0;
            r_mask <= '0;
            r_edge <= '0;
            r_en   <= '0;
            r_prev <= '0;
            r_sync <= '0;
            r_cnt  <= '0;
            r_plen <= '0;
            r_dat  <= '0;
            r_ack  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_ack  <= w_acc;
            if (w_acc) r_dat <= w_rdata;
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_prev <= w_sync;
            // a rise arriving with a clear on the same bit keeps the bit set
            r_edge <= (r_edge & ~w_w1c) | w_rise;
            r_irq  <= |(r_edge & r_en);
            if (w_wr)
                case (w_sel)
                    4'd0: r_out  <= w_d;
                    4'd1: r_out  <= r_out | w_d;
                    4'd2: r_out  <= r_out & ~w_d;
                    4'd3: r_out  <= r_out ^ w_d;
                    4'd4: r_dir  <= w_d;
                    4'd7: r_plen <= wb_dat_i[PULSE_CW-1:0];
                    4'd9: r_en   <= w_d;
                    default: ;
                endcase
            // retrigger reloads the shared counter, extending every bit already in the mask
            if (w_pls) begin
                r_cnt  <= r_plen;
                r_mask <= r_mask | w_d;
            end else if (w_active) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == PULSE_CW'(1)) r_mask <= '0;
            end
        end
    end
endmodule

// File: tb/tb_wb_gpio_pulse.sv
// tb_wb_gpio_pulse: directed bench for wb_gpio_pulse (register map, pulse engine, edge/irq, reset)
module tb_wb_gpio_pulse;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;
    int          n_chk = 0;
    int          n_err = 0;
    int          n0 = 0, n1 = 0, n2 = 0, n3 = 0;
    logic [31:0] q;
    typedef struct {
        logic        we;
        logic [5:0]  adr;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t v[$];

    wb_gpio_pulse #(.GPIO_WIDTH(8), .PULSE_CW(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n0 += int'(gpio_out[0]);
        n1 += int'(gpio_out[1]);
        n2 += int'(gpio_out[2]);
        n3 += int'(gpio_out[3]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // strobe is held across the ack edge too, so a second ack would be caught
    task automatic bus(input logic we, input logic [5:0] adr, input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        wb_adr_i = {26'd0, adr};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("ack adr=%02h", adr), 32'(wb_ack_o), 32'd1);
        rd = wb_dat_o;
        @(posedge clk);
        #1;
        check($sformatf("ack_single adr=%02h", adr), 32'(wb_ack_o), 32'd0);
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    initial begin
        int s0, s1, s2, s3;
        v.push_back('{1'b1, 6'h00, 32'h0F, 32'h0});
        v.push_back('{1'b1, 6'h04, 32'h30, 32'h0});
        v.push_back('{1'b1, 6'h08, 32'h01, 32'h0});
        v.push_back('{1'b1, 6'h0C, 32'h81, 32'h0});
        v.push_back('{1'b0, 6'h00, 32'h0,  32'hBF});
        v.push_back('{1'b0, 6'h04, 32'h0,  32'h0});
        v.push_back('{1'b0, 6'h08, 32'h0,  32'h0});
        v.push_back('{1'b0, 6'h0C, 32'h0,  32'h0});
        v.push_back('{1'b1, 6'h10, 32'hFFFF_FFA5, 32'h0});
        v.push_back('{1'b0, 6'h10, 32'h0,  32'hA5});
        v.push_back('{1'b1, 6'h3C, 32'hFF, 32'h0});
        v.push_back('{1'b0, 6'h3C, 32'h0,  32'h0});
        v.push_back('{1'b0, 6'h00, 32'h0,  32'hBF});
        v.push_back('{1'b0, 6'h14, 32'h0,  32'h0});
        v.push_back('{1'b1, 6'h1C, 32'hABCD_1234, 32'h0});
        v.push_back('{1'b0, 6'h1C, 32'h0,  32'h1234});
        v.push_back('{1'b1, 6'h24, 32'h02, 32'h0});
        v.push_back('{1'b0, 6'h24, 32'h0,  32'h02});
        v.push_back('{1'b0, 6'h18, 32'h0,  32'h0});

        #12;
        check("reset gpio_out", 32'(gpio_out), 32'h0);
        check("reset gpio_oe", 32'(gpio_oe), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset ack", 32'(wb_ack_o), 32'h0);
        check("reset dat_o", wb_dat_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (v[i]) begin
            bus(v[i].we, v[i].adr, v[i].d, q);
            if (!v[i].we) check($sformatf("vec%0d read adr=%02h", i, v[i].adr), q, v[i].exp);
        end
        check("pins out", 32'(gpio_out), 32'hBF);
        check("pins oe", 32'(gpio_oe), 32'hA5);

        bus(1'b1, 6'h00, 32'h0, q);
        bus(1'b1, 6'h1C, 32'd5, q);
        s2 = n2;
        s3 = n3;
        bus(1'b1, 6'h18, 32'h04, q);
        bus(1'b1, 6'h18, 32'h08, q);
        repeat (12) @(negedge clk);
        check("retrigger bit2 cycles", 32'(n2 - s2), 32'd7);
        check("retrigger bit3 cycles", 32'(n3 - s3), 32'd5);
        check("pulse end pins", 32'(gpio_out), 32'h0);

        s0 = n0;
        s1 = n1;
        bus(1'b1, 6'h1C, 32'd0, q);
        bus(1'b1, 6'h18, 32'h01, q);
        bus(1'b0, 6'h18, 32'h0, q);
        check("plen0 pulse read", q, 32'h0);
        check("plen0 pins", 32'(gpio_out), 32'h0);
        bus(1'b1, 6'h1C, 32'd3, q);
        bus(1'b1, 6'h18, 32'h02, q);
        bus(1'b0, 6'h18, 32'h0, q);
        check("pulse read active", q, 32'h02);
        repeat (6) @(negedge clk);
        check("plen3 bit1 cycles", 32'(n1 - s1), 32'd3);
        check("plen0 mask ignored bit0", 32'(n0 - s0), 32'd0);
        bus(1'b0, 6'h18, 32'h0, q);
        check("pulse read idle", q, 32'h0);

        bus(1'b1, 6'h00, 32'h04, q);
        bus(1'b1, 6'h1C, 32'd5, q);
        bus(1'b1, 6'h18, 32'h04, q);
        bus(1'b1, 6'h08, 32'h04, q);
        @(negedge clk);
        check("clr mid pulse held", 32'(gpio_out[2]), 32'd1);
        @(negedge clk);
        check("pulse last cycle", 32'(gpio_out[2]), 32'd1);
        @(negedge clk);
        check("pulse over out ends", 32'(gpio_out[2]), 32'd0);
        bus(1'b0, 6'h00, 32'h0, q);
        check("out after clr", q, 32'h0);

        check("irq idle", 32'(irq), 32'h0);
        @(negedge clk);
        gpio_in[1] = 1'b1;
        bus(1'b0, 6'h14, 32'h0, q);
        check("in latency", q, 32'h0);
        bus(1'b0, 6'h14, 32'h0, q);
        check("in sync", q, 32'h02);
        bus(1'b0, 6'h20, 32'h0, q);
        check("edge set", q, 32'h02);
        check("irq set", 32'(irq), 32'h1);
        gpio_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        bus(1'b1, 6'h20, 32'h02, q);
        bus(1'b0, 6'h20, 32'h0, q);
        check("edge w1c", q, 32'h0);
        check("irq cleared", 32'(irq), 32'h0);
        @(negedge clk);
        gpio_in[1] = 1'b1;
        @(negedge clk);
        bus(1'b1, 6'h20, 32'h02, q);
        bus(1'b0, 6'h20, 32'h0, q);
        check("edge set wins", q, 32'h02);
        check("irq after set wins", 32'(irq), 32'h1);

        bus(1'b1, 6'h00, 32'h81, q);
        bus(1'b1, 6'h10, 32'hFF, q);
        bus(1'b1, 6'h18, 32'h10, q);
        @(negedge clk);
        wb_adr_i = 32'h0;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        @(posedge clk);
        #2;
        check("pre-reset ack", 32'(wb_ack_o), 32'h1);
        check("pre-reset pins", 32'(gpio_out), 32'h91);
        rst = 1'b1;
        #1;
        check("async reset gpio_out", 32'(gpio_out), 32'h0);
        check("async reset gpio_oe", 32'(gpio_oe), 32'h0);
        check("async reset irq", 32'(irq), 32'h0);
        check("async reset ack", 32'(wb_ack_o), 32'h0);
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        bus(1'b0, 6'h20, 32'h0, q);
        check("edge at reset release", q, 32'h02);
        bus(1'b0, 6'h1C, 32'h0, q);
        check("plen after reset", q, 32'h0);
        check("pins after reset", 32'(gpio_out), 32'h0);
        check("irq after reset", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
